jtframe_rom_arb: RTL

JTFRAME_ROM_ARB -- requirements
Module: jtframe_rom_arb

---
 rtl/jtframe_rom_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/jtframe_rom_arb.sv
// Multi-slot ROM read arbiter: one 32-bit cached word per slot, misses are
// serialised onto a single SDRAM read port (fixed priority or round-robin).
module jtframe_rom_arb #(
    parameter int                  NSLOT  = 4,
    parameter int                  SAW    = 18,
    parameter logic [NSLOT-1:0]    DW16   = '0,
    parameter logic [NSLOT*22-1:0] OFFSET = '0,
    parameter bit                  RROBIN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic [NSLOT-1:0]      slot_cs,
    input  logic [NSLOT*SAW-1:0]  slot_addr,
    output logic [NSLOT-1:0]      slot_ok,
    output logic [NSLOT*16-1:0]   slot_dout,
    output logic                  sdram_req,
    output logic [21:0]           sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [31:0]           data_read
);

    localparam int IW = $clog2(NSLOT);
    // Word addresses share one width; 8-bit slots zero-extend by one bit.
    localparam int WW = SAW - 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [21:0]        addr_q, addr_d;
    logic [IW-1:0]      win_q, win_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [WW-1:0]      wa_q, wa_d;
    logic [NSLOT-1:0]   valid_q, valid_d;
    logic [WW-1:0]      tag_q   [NSLOT];
    logic [WW-1:0]      tag_d   [NSLOT];
    logic [31:0]        cache_q [NSLOT];
    logic [31:0]        cache_d [NSLOT];

    logic [WW-1:0]      word_addr [NSLOT];
    logic [NSLOT-1:0]   hit;
    logic [NSLOT-1:0]   pending;
    logic               found;
    logic [IW-1:0]      grant;

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            logic [SAW-1:0] addr;
            assign addr = slot_addr[gi*SAW +: SAW];

            if (DW16[gi]) begin : g_w16
                assign word_addr[gi]          = addr[SAW-1:1];
                assign slot_dout[gi*16 +: 16] = addr[0] ? cache_q[gi][31:16] : cache_q[gi][15:0];
            end else begin : g_w8
                assign word_addr[gi]          = {1'b0, addr[SAW-1:2]};
                assign slot_dout[gi*16 +: 16] = {8'd0, cache_q[gi][{addr[1:0], 3'b000} +: 8]};
            end

            assign hit[gi]     = valid_q[gi] & (tag_q[gi] == word_addr[gi]) & ~downloading;
            assign pending[gi] = slot_cs[gi] & ~hit[gi] & ~downloading;
            assign slot_ok[gi] = slot_cs[gi] & hit[gi];
        end
    endgenerate

    // Round-robin search starts one past the last granted slot.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NSLOT; k++) begin
            idx = RROBIN ? (int'(ptr_q) + 1 + k) % NSLOT : k;
            if (!found && pending[idx]) begin
                found = 1'b1;
                grant = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        wa_d    = wa_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        cache_d = cache_q;

        if (downloading) begin
            state_d = IDLE;
            req_d   = 1'b0;
            valid_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        win_d   = grant;
                        ptr_d   = grant;
                        wa_d    = word_addr[grant];
                        addr_d  = OFFSET[int'(grant)*22 +: 22] + 22'({word_addr[grant], 1'b0});
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        req_d   = 1'b0;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    // Fill under the latched tag even if the slot address moved on.
                    if (data_rdy) begin
                        cache_d[win_q] = data_read;
                        tag_d[win_q]   = wa_q;
                        valid_d[win_q] = 1'b1;
                        state_d        = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            win_q   <= '0;
            ptr_q   <= IW'(NSLOT - 1);
            wa_q    <= '0;
            valid_q <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                tag_q[i]   <= '0;
                cache_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            wa_q    <= wa_d;
            valid_q <= valid_d;
            for (int i = 0; i < NSLOT; i++) begin
                tag_q[i]   <= tag_d[i];
                cache_q[i] <= cache_d[i];
            end
        end
    end

    assign sdram_req  = req_q & ~downloading;
    assign sdram_addr = addr_q;

endmodule
